// File: rtl/id_stage.sv
// id_stage: instruction decode with 8x16 register file, operand forwarding,
// load-use stall detection and wrong-path squash for the 16-bit pipeline.
module id_stage #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          state,
    input  logic [DW-1:0] id_ir,
    input  logic [DW-1:0] ex_alu,
    input  logic [DW-1:0] mem_ir,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] wb_ir,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    output logic [DW-1:0] ex_ir,
    output logic [DW-1:0] reg_A,
    output logic [DW-1:0] reg_B,
    output logic [DW-1:0] smdr,
    output logic          stall
);
    localparam logic EXEC = 1'b1;
    localparam logic [4:0] LOAD = 5'd2, STORE = 5'd3, SLL = 5'd4, SLA = 5'd5, SRL = 5'd6, SRA = 5'd7;
    localparam logic [4:0] ADD = 5'd8, ADDI = 5'd9, SUB = 5'd10, SUBI = 5'd11, CMP = 5'd12;
    localparam logic [4:0] AND = 5'd13, OR = 5'd14, XOR = 5'd15, LDIH = 5'd16;
    localparam logic [4:0] JUMP = 5'd24, JMPR = 5'd25, BZ = 5'd26, BNZ = 5'd27;
    localparam logic [4:0] BN = 5'd28, BNN = 5'd29, BC = 5'd30, BNC = 5'd31;

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [DW-1:0] ex_ir_q, ex_ir_d, reg_a_q, reg_a_d, reg_b_q, reg_b_d, smdr_q, smdr_d;
    logic [DW-1:0] a_sel, b_sel, s_sel;
    logic [4:0]    op;
    logic [2:0]    rd, rs1, rs2;
    logic          use_rd, use_rs1, use_rs2, hazard, run, bubble;
    logic          unused_bits;

    function automatic logic writes_reg(input logic [4:0] o);
        return o inside {ADD, SUB, AND, OR, XOR, SLL, SRL, SLA, SRA, ADDI, SUBI, LDIH, LOAD};
    endfunction

    // Youngest producer wins; a LOAD in EX has no value yet and is covered by the stall.
    function automatic logic [DW-1:0] fwd(input logic [2:0] n);
        if (writes_reg(ex_ir_q[15:11]) && ex_ir_q[15:11] != LOAD && ex_ir_q[10:8] == n) return ex_alu;
        if (writes_reg(mem_ir[15:11]) && mem_ir[10:8] == n) return mem_data;
        if (writes_reg(wb_ir[15:11]) && wb_ir[10:8] == n) return wb_data;
        return rf_q[n];
    endfunction

    assign unused_bits = ^{mem_ir[7:0], wb_ir[7:0]};

    always_comb begin
        op      = id_ir[15:11];
        rd      = id_ir[10:8];
        rs1     = id_ir[6:4];
        rs2     = id_ir[2:0];
        a_sel   = '0;
        b_sel   = '0;
        s_sel   = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (op)
            ADD, SUB, AND, OR, XOR, CMP: begin
                a_sel = fwd(rs1);
                b_sel = fwd(rs2);
                {use_rs1, use_rs2} = 2'b11;
            end
            SLL, SLA, SRL, SRA, LOAD, STORE: begin
                a_sel   = fwd(rs1);
                b_sel   = {{(DW-4){1'b0}}, id_ir[3:0]};
                s_sel   = op == STORE ? fwd(rd) : '0;
                use_rs1 = 1'b1;
                use_rd  = op == STORE;
            end
            ADDI, SUBI, LDIH, JMPR, BZ, BNZ, BN, BNN, BC, BNC: begin
                a_sel  = fwd(rd);
                b_sel  = op == LDIH ? {id_ir[7:0], {(DW-8){1'b0}}} : {{(DW-8){1'b0}}, id_ir[7:0]};
                use_rd = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        run     = state == EXEC;
        hazard  = ex_ir_q[15:11] == LOAD && ((use_rd && rd == ex_ir_q[10:8]) ||
                  (use_rs1 && rs1 == ex_ir_q[10:8]) || (use_rs2 && rs2 == ex_ir_q[10:8]));
        stall   = run && hazard;
        bubble  = flush || hazard || ex_ir_q[15:11] == JUMP;
        ex_ir_d = !run ? ex_ir_q : bubble ? '0 : id_ir;
        reg_a_d = !run ? reg_a_q : bubble ? '0 : a_sel;
        reg_b_d = !run ? reg_b_q : bubble ? '0 : b_sel;
        smdr_d  = !run ? smdr_q  : bubble ? '0 : s_sel;
        rf_d    = rf_q;
        if (run && writes_reg(wb_ir[15:11])) rf_d[wb_ir[10:8]] = wb_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_ir_q <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            smdr_q  <= '0;
            rf_q    <= '{default: '0};
        end else begin
            ex_ir_q <= ex_ir_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            smdr_q  <= smdr_d;
            rf_q    <= rf_d;
        end
    end

    assign ex_ir = ex_ir_q;
    assign reg_A = reg_a_q;
    assign reg_B = reg_b_q;
    assign smdr  = smdr_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed test-plan steps plus randomized traffic, checked
// against an instruction-level reference model of the decode stage.
module tb_id_stage;
    localparam logic [4:0] NOP = 5'd0, HALT = 5'd1, LOAD = 5'd2, STORE = 5'd3;
    localparam logic [4:0] SLL = 5'd4, SLA = 5'd5, SRL = 5'd6, SRA = 5'd7;
    localparam logic [4:0] ADD = 5'd8, ADDI = 5'd9, SUB = 5'd10, SUBI = 5'd11, CMP = 5'd12;
    localparam logic [4:0] AND = 5'd13, OR = 5'd14, XOR = 5'd15, LDIH = 5'd16;
    localparam logic [4:0] JUMP = 5'd24, JMPR = 5'd25, BZ = 5'd26, BNZ = 5'd27;
    localparam logic [4:0] BN = 5'd28, BNN = 5'd29, BC = 5'd30, BNC = 5'd31;

    logic        clock = 1'b0, reset = 1'b0, state = 1'b0, flush = 1'b0;
    logic [15:0] id_ir = '0, ex_alu = '0, mem_ir = '0, mem_data = '0, wb_ir = '0, wb_data = '0;
    logic [15:0] ex_ir, reg_A, reg_B, smdr;
    logic        stall, obs_stall;
    int unsigned checks = 0, errors = 0;

    logic [15:0] m_ex, m_a, m_b, m_s;
    logic [15:0] m_rf [8];
    logic [4:0]  ops [26] = '{NOP, HALT, LOAD, STORE, SLL, SLA, SRL, SRA, ADD, ADDI, SUB, SUBI, CMP,
                              AND, OR, XOR, LDIH, 5'd17, JUMP, JMPR, BZ, BNZ, BN, BNN, BC, BNC};

    id_stage dut (
        .clock(clock), .reset(reset), .state(state), .id_ir(id_ir), .ex_alu(ex_alu),
        .mem_ir(mem_ir), .mem_data(mem_data), .wb_ir(wb_ir), .wb_data(wb_data), .flush(flush),
        .ex_ir(ex_ir), .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wr(input logic [15:0] ir);
        return ir[15:11] inside {ADD, SUB, AND, OR, XOR, SLL, SRL, SLA, SRA, ADDI, SUBI, LDIH, LOAD};
    endfunction

    function automatic logic [15:0] m_val(input logic [2:0] n);
        if (m_wr(m_ex) && m_ex[15:11] != LOAD && m_ex[10:8] == n) return ex_alu;
        if (m_wr(mem_ir) && mem_ir[10:8] == n) return mem_data;
        if (m_wr(wb_ir) && wb_ir[10:8] == n) return wb_data;
        return m_rf[n];
    endfunction

    // Operand table by opcode family; mask records every register the instruction reads.
    task automatic m_decode(input logic [15:0] ir, output logic [15:0] a, b, s, output logic [7:0] mask);
        logic [4:0] o = ir[15:11];
        a = 0; b = 0; s = 0; mask = 0;
        if (o inside {ADD, SUB, AND, OR, XOR, CMP}) begin
            a = m_val(ir[6:4]); b = m_val(ir[2:0]);
            mask[ir[6:4]] = 1; mask[ir[2:0]] = 1;
        end else if (o inside {SLL, SLA, SRL, SRA, LOAD, STORE}) begin
            a = m_val(ir[6:4]); b = 16'(ir[3:0]); mask[ir[6:4]] = 1;
            if (o == STORE) begin s = m_val(ir[10:8]); mask[ir[10:8]] = 1; end
        end else if (o inside {ADDI, SUBI, LDIH, JMPR, BZ, BNZ, BN, BNN, BC, BNC}) begin
            a = m_val(ir[10:8]); b = o == LDIH ? {ir[7:0], 8'h00} : 16'(ir[7:0]);
            mask[ir[10:8]] = 1;
        end
    endtask

    task automatic step(input logic [15:0] ir, ea, mi, md, wi, wd, input logic fl, st);
        logic [15:0] a, b, s;
        logic [7:0]  mask;
        logic        e_stall;
        id_ir = ir; ex_alu = ea; mem_ir = mi; mem_data = md; wb_ir = wi; wb_data = wd;
        flush = fl; state = st;
        #1;
        m_decode(ir, a, b, s, mask);
        e_stall = st && m_ex[15:11] == LOAD && mask[m_ex[10:8]];
        obs_stall = stall;
        chk("stall", 16'(stall), 16'(e_stall));
        @(posedge clock);
        if (st) begin
            if (fl || e_stall || m_ex[15:11] == JUMP) {m_ex, m_a, m_b, m_s} = '0;
            else {m_ex, m_a, m_b, m_s} = {ir, a, b, s};
            if (m_wr(wi)) m_rf[wi[10:8]] = wd;
        end
        #1;
        chk("ex_ir", ex_ir, m_ex);
        chk("reg_A", reg_A, m_a);
        chk("reg_B", reg_B, m_b);
        chk("smdr", smdr, m_s);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_ex_ir", ex_ir, 16'h0);
        chk("rst_reg_A", reg_A, 16'h0);
        chk("rst_reg_B", reg_B, 16'h0);
        chk("rst_smdr", smdr, 16'h0);
        chk("rst_stall", 16'(stall), 16'h0);
        {m_ex, m_a, m_b, m_s} = '0;
        foreach (m_rf[i]) m_rf[i] = '0;
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [15:0] ir, add_r5;
        @(posedge clock);
        #1 do_reset();
        // EX forwarding beats a conflicting MEM match.
        step({ADDI, 3'd1, 8'd5}, 0, 0, 0, 0, 0, 0, 1);
        step({ADD, 3'd2, 1'b0, 3'd1, 1'b0, 3'd1}, 16'h0005, {ADDI, 3'd1, 8'd9}, 16'h9999, 0, 0, 0, 1);
        chk("exfwd_A", reg_A, 16'h0005);
        chk("exfwd_B", reg_B, 16'h0005);
        // Load-use bubble, then MEM forwarding of the load data.
        ir = {ADD, 3'd4, 1'b0, 3'd3, 1'b0, 3'd0};
        step({LOAD, 3'd3, 1'b0, 3'd0, 4'd2}, 0, 0, 0, 0, 0, 0, 1);
        step(ir, 0, 0, 0, 0, 0, 0, 1);
        chk("lu_stall", 16'(obs_stall), 16'h1);
        chk("lu_bubble", ex_ir, 16'h0);
        step(ir, 0, {LOAD, 3'd3, 1'b0, 3'd0, 4'd2}, 16'hBEEF, 0, 0, 0, 1);
        chk("lu_stall_end", 16'(obs_stall), 16'h0);
        chk("lu_A", reg_A, 16'hBEEF);
        // Same-cycle writeback read.
        step({STORE, 3'd6, 1'b0, 3'd5, 4'd0}, 0, 0, 0, {ADDI, 3'd6, 8'h00}, 16'h1234, 0, 1);
        chk("wt_smdr", smdr, 16'h1234);
        // JUMP squash.
        step({JUMP, 11'h123}, 0, 0, 0, 0, 0, 0, 1);
        chk("jmp_ex", ex_ir, {JUMP, 11'h123});
        step(16'h0801, 0, 0, 0, 0, 0, 0, 1);
        chk("jmp_squash", ex_ir, 16'h0);
        // Flush coinciding with a load-use stall.
        add_r5 = {ADD, 3'd5, 1'b0, 3'd2, 1'b0, 3'd2};
        step({LOAD, 3'd2, 1'b0, 3'd0, 4'd0}, 0, 0, 0, 0, 0, 0, 1);
        step(add_r5, 0, 0, 0, 0, 0, 1, 1);
        chk("fl_stall", 16'(obs_stall), 16'h1);
        chk("fl_ex", ex_ir, 16'h0);
        step(add_r5, 0, 0, 0, 0, 0, 0, 1);
        chk("fl_nostall", 16'(obs_stall), 16'h0);
        chk("fl_issue", ex_ir, add_r5);
        // Not in exec: everything holds, including the register file.
        for (int i = 0; i < 3; i++) begin
            step(16'($urandom), 16'($urandom), 0, 0, {ADDI, 3'd7, 8'h00}, 16'hFFFF, 0, 0);
            chk("hold_ex", ex_ir, add_r5);
        end
        step({ADDI, 3'd7, 8'd0}, 0, 0, 0, 0, 0, 0, 1);
        chk("hold_rf", reg_A, 16'h0);
        // Randomized traffic.
        ir = 0;
        for (int i = 0; i < 500; i++) begin
            if (!obs_stall)
                ir = {($urandom_range(3) == 0) ? LOAD : ops[$urandom_range(25)], 11'($urandom)};
            step(ir, 16'($urandom), {ops[$urandom_range(25)], 11'($urandom)}, 16'($urandom),
                 {ops[$urandom_range(25)], 11'($urandom)}, 16'($urandom),
                 $urandom_range(9) == 0, $urandom_range(7) != 0);
        end
        // Reset mid-run clears the register file.
        step({LOAD, 3'd1, 1'b0, 3'd2, 4'd1}, 0, 0, 0, {ADDI, 3'd1, 8'h00}, 16'hAAAA, 0, 1);
        do_reset();
        step({LOAD, 3'd1, 1'b0, 3'd1, 4'd3}, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_rf", reg_A, 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage 16-bit pipeline, between fetch and execute.
- Captures the instruction word from fetch and holds the 8x16 general register file, written from writeback.
- Selects and forwards operands, detects load-use hazards (stall) and squashes wrong-path instructions after JUMP and taken branches.
- Produces ex_ir, reg_A, reg_B and smdr for execute.

Parameters:
- NREG, 8, number of general registers; 3-bit register fields.
- DW, 16, data and instruction width.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- state  input  1  CPU run state; pipeline advances only when state == `exec
- id_ir  input  16  instruction from fetch (fetch's id_iro)
- ex_alu  input  16  ALU result currently in EX
- mem_ir  input  16  instruction in MEM
- mem_data  input  16  MEM result (ALU result or load data)
- wb_ir  input  16  instruction in WB
- wb_data  input  16  writeback value
- flush  input  1  taken branch or JMPR resolved in MEM this cycle
- ex_ir  output  16  registered instruction to EX; also fed back internally
- reg_A  output  16  registered operand A
- reg_B  output  16  registered operand B
- smdr  output  16  registered store data
- stall  output  1  combinational; fetch must hold pc and id_iro while high

Behaviour:
Fields:
- op = [15:11]; rd = [10:8]; rs1 = [6:4]; rs2 = [2:0]; imm8 = [7:0]; off4 = [3:0].
Operand selection by op (opcodes from the shared define file):
- R-type ALU (ADD, SUB, AND, OR, XOR, CMP, SLL, SRL, SLA, SRA): A = R[rs1], B = R[rs2]. Shifts: B = {12'b0, off4}.
- ADDI, SUBI: A = R[rd], B = {8'b0, imm8}. LDIH: A = R[rd], B = {imm8, 8'b0}.
- LOAD, STORE: A = R[rs1], B = {12'b0, off4}. STORE only: smdr = R[rd].
- JMPR and BZ, BNZ, BN, BNN, BC, BNC: A = R[rd], B = {8'b0, imm8}.
- JUMP, NOP, HALT: A = B = 0.
- smdr = 0 for every op other than STORE.
Register writes and read paths:
- writes_reg(op) is true for R-type (except CMP), ADDI, SUBI, LDIH and LOAD. Destination is always rd.
- Register file writes R[wb_ir rd] <= wb_data on the rising edge when state == `exec and writes_reg(wb_ir op).
- Every register-sourced operand (A, B or smdr) takes the first match of:
  1. EX: ex_ir writes_reg, not LOAD, rd matches -> ex_alu.
  2. MEM: mem_ir writes_reg, rd matches -> mem_data.
  3. WB: wb_ir writes_reg, rd matches -> wb_data (write-through bypass).
  4. Otherwise -> R[n].
Hazards and squash:
- Load-use: stall = 1 when ex_ir op == LOAD and its rd equals any register field that the current id_ir actually reads (per the table above). stall is gated by state == `exec.
- Squash: insert a bubble when flush = 1, or when ex_ir op == JUMP (the instruction behind a JUMP is wrong-path).
Register update at the rising edge when state == `exec:
- Priority is flush > stall > JUMP squash > normal.
- flush: ex_ir <= NOP (16'h0000), A/B/smdr <= 0.
- stall: ex_ir <= NOP, A/B/smdr <= 0; nothing else is captured. Fetch holds, so the same id_ir is re-decoded next cycle.
- JUMP squash: ex_ir <= NOP, A/B/smdr <= 0.
- Normal: ex_ir <= id_ir; A/B/smdr <= selected values.
- When state != `exec, all registers, including the register file, hold.
Latency and reset:
- Decode latency is 1 cycle; a load-use hazard costs 1 bubble.
- reset low (asynchronous) clears ex_ir, reg_A, reg_B, smdr and all R[0..7] to 0. stall then evaluates to 0, because a NOP in ex_ir is not a LOAD.
- Reset mid-stall discards the held instruction.
Edge cases:
- Arithmetic is none beyond field extension; all values are unsigned zero-extended.
- R0 is an ordinary writable register.
- Same-cycle WB write and read of one register returns wb_data.

Test Plan:
- Reset: drive reset low mid-run -> ex_ir, reg_A, reg_B, smdr = 0; a LOAD of R1 after release reads 0.
- EX forward: ADDI R1,#5 then ADD R2,R1,R1 with ex_alu = 16'h0005 -> reg_A = reg_B = 16'h0005 on the ADD's cycle. A MEM match on R1 with a different value is ignored.
- Load-use: LOAD R3,(R0+2) then ADD R4,R3,R0 -> stall = 1 for exactly 1 cycle and ex_ir = 0. Next cycle, with mem_data = 16'hBEEF, the ADD issues with reg_A = 16'hBEEF.
- Write-through: wb_ir writes R6 = 16'h1234 in the same cycle id_ir = STORE R6,(R5+0) -> smdr = 16'h1234.
- JUMP squash: id_ir = JUMP, then 16'h0801 -> ex_ir sequence is JUMP, 0000. Assert flush together with a stall in one cycle -> ex_ir = 0 and stall has no further effect.
- state hold: keep state != `exec for 3 cycles with wb activity -> ex_ir and all registers unchanged.
